// File: rtl/edge_detector_pkg.sv
// Shared types and helpers for the level-to-pulse edge detector.
// Mode encoding and the detect function live here so every user agrees.
package edge_detector_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  localparam int SYNC_STAGES_DEF = 0;

  function automatic logic edge_det(
    input edge_mode_e mode,
    input logic       s,
    input logic       q
  );
    logic r;
    r = 1'b0;
    unique case (mode)
      EDGE_RISE: r = s & ~q;
      EDGE_FALL: r = ~s & q;
      EDGE_BOTH: r = s ^ q;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Optional flop chain in front of the detector for asynchronous inputs.
// With STAGES=0 it is a plain wire.
module edge_sync
  import edge_detector_pkg::*;
#(
  parameter int   STAGES      = SYNC_STAGES_DEF,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (STAGES == 0) begin : g_pass
    logic unused_pass;
    assign unused_pass = clk ^ rst;
    assign q = d;
  end else begin : g_chain
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        chain <= {STAGES{RESET_LEVEL}};
      end else begin
        chain[0] <= d;
        for (int i = 1; i < STAGES; i++) begin
          chain[i] <= chain[i-1];
        end
      end
    end

    assign q = chain[STAGES-1];
  end

endmodule

// File: rtl/edge_detector.sv
// Level-to-pulse converter: optional sync chain, history flop,
// mode-selected edge detect and a registered one-cycle output pulse.
module edge_detector
  import edge_detector_pkg::*;
#(
  parameter edge_mode_e EDGE_MODE   = EDGE_RISE,
  parameter int         SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic       RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic levelin,
  output logic outpulse
);

  logic s;
  logic lvl_q;

  edge_sync #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (levelin),
    .q   (s)
  );

  // Output is a flop so downstream sees a glitch-free strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_q    <= RESET_LEVEL;
      outpulse <= 1'b0;
    end else begin
      lvl_q    <= s;
      outpulse <= edge_det(EDGE_MODE, s, lvl_q);
    end
  end

endmodule

// File: tb/tb_edge_detector.sv
// Scoreboard bench: four detector variants share one input stream.
// Expected pulses come from a behavioural model pushed at drive time.
module tb_edge_detector;
  import edge_detector_pkg::*;

  logic clk;
  logic rst;
  logic levelin;
  logic out_r, out_f, out_b, out_s;
  logic [3:0] outs;

  assign outs = {out_r, out_f, out_b, out_s};

  edge_detector u_rise (
    .clk(clk), .rst(rst), .levelin(levelin), .outpulse(out_r)
  );
  edge_detector #(.EDGE_MODE(EDGE_FALL)) u_fall (
    .clk(clk), .rst(rst), .levelin(levelin), .outpulse(out_f)
  );
  edge_detector #(.EDGE_MODE(EDGE_BOTH)) u_both (
    .clk(clk), .rst(rst), .levelin(levelin), .outpulse(out_b)
  );
  edge_detector #(.SYNC_STAGES(2)) u_sync2 (
    .clk(clk), .rst(rst), .levelin(levelin), .outpulse(out_s)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] sb[$];
  logic [3:0] exp_v;

  // reference state: last sampled level, and 2-deep delay for sync model
  logic m_prev;
  logic m_c0, m_c1, m_prev2;

  function automatic void model_reset();
    m_prev  = 1'b0;
    m_c0    = 1'b0;
    m_c1    = 1'b0;
    m_prev2 = 1'b0;
  endfunction

  task automatic drive(input logic lvl, input bit glitch = 0);
    logic e_r, e_f, e_b, e_s, s2;
    levelin = lvl;
    e_r = lvl & ~m_prev;
    e_f = ~lvl & m_prev;
    e_b = lvl ^ m_prev;
    m_prev = lvl;
    s2 = m_c1;
    m_c1 = m_c0;
    m_c0 = lvl;
    e_s = s2 & ~m_prev2;
    m_prev2 = s2;
    sb.push_back({e_r, e_f, e_b, e_s});
    if (glitch) begin
      #3 levelin = ~lvl;
      #3 levelin = lvl;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    levelin = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      levelin = ~levelin;
      n_checks++;
      if (outs !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: got %b expected 0000", i, outs);
      end
    end
    levelin = 1'b0;
    #9;
    rst = 1'b1;
  endtask

  task automatic test_single_rise();
    drive(1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 6; i++) begin
      drive(1'b1);
      exp_v = sb.pop_front();
      n_checks++;
      if (outs !== exp_v) begin
        n_fail++;
        $display("FAIL single_rise cyc%0d: got %b expected %b", i, outs, exp_v);
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1);
      exp_v = sb.pop_front();
      n_checks++;
      if (outs !== exp_v) begin
        n_fail++;
        $display("FAIL hold_high cyc%0d: got %b expected %b", i, outs, exp_v);
      end
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0);
      exp_v = sb.pop_front();
      n_checks++;
      if (outs !== exp_v) begin
        n_fail++;
        $display("FAIL hold_low cyc%0d: got %b expected %b", i, outs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      drive(1'(i % 2));
      exp_v = sb.pop_front();
      n_checks++;
      if (outs !== exp_v) begin
        n_fail++;
        $display("FAIL alternate cyc%0d: got %b expected %b", i, outs, exp_v);
      end
    end
    // both-mode must stay high through the middle of the toggle run
    for (int i = 0; i < 6; i++) begin
      drive(1'(i % 2));
      exp_v = sb.pop_front();
      n_checks++;
      if (out_b !== 1'b1 || outs !== exp_v) begin
        n_fail++;
        $display("FAIL both_cont cyc%0d: got %b expected %b", i, outs, exp_v);
      end
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1);
      exp_v = sb.pop_front();
      n_checks++;
      if (outs !== exp_v) begin
        n_fail++;
        $display("FAIL glitch cyc%0d: got %b expected %b", i, outs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    drive(1'b0);
    void'(sb.pop_front());
    drive(1'b0);
    void'(sb.pop_front());
    drive(1'b1);
    exp_v = sb.pop_front();
    n_checks++;
    if (out_r !== 1'b1 || outs !== exp_v) begin
      n_fail++;
      $display("FAIL pre_reset_pulse: got %b expected %b", outs, exp_v);
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (outs !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset_drop: got %b expected 0000", outs);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (outs !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_held_high: got %b expected 0000", outs);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1);
      exp_v = sb.pop_front();
      n_checks++;
      if (outs !== exp_v) begin
        n_fail++;
        $display("FAIL post_reset cyc%0d: got %b expected %b", i, outs, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 50; i++) begin
      drive(1'($urandom_range(0, 1)));
      exp_v = sb.pop_front();
      n_checks++;
      if (outs !== exp_v) begin
        n_fail++;
        $display("FAIL random cyc%0d: got %b expected %b", i, outs, exp_v);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_rise();
    test_hold();
    test_back_to_back();
    test_glitch();
    test_reset_mid_pulse();
    test_random();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
